cmos_capture_pack: RTL and testbench

- Write-side front end of the SDRAM frame buffer; sits directly upstream of the SDRAM top-level write port.
- Takes the 8-bit camera DVP stream (vsync/href/data) in the camera pixel-clock domain and packs byte pairs into 16-bit RGB565 words, producing wr_en/wr_data.
- Issues wr_load at each frame start, so the SDRAM write address and write FIFO realign per frame.
- Discards frames until camera configuration has settled, and flags the first complete frame so the read path (sdram_read_valid) can be enabled.

---
 rtl/sdram_cam_pkg.sv | 9 +
 rtl/dvp_edge_sync.sv | 34 +++
 rtl/cmos_capture_pack.sv | 137 +++++++++++++
 tb/tb_cmos_capture_pack.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sdram_cam_pkg.sv
// sdram_cam_pkg: capture FSM state encoding, default 640x480 resolution, RGB565 word width
package sdram_cam_pkg;
    localparam logic [1:0] ST_WAIT_CFG = 2'd0;
    localparam logic [1:0] ST_SKIP     = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_LINES  = 480;
    localparam int PIX_W        = 16;
endpackage

// File: rtl/dvp_edge_sync.sv
// dvp_edge_sync: registers cam_vsync/cam_href/cam_data once; outputs s_href, s_data, vs_rise, href_fall
module dvp_edge_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       s_href,
    output logic [7:0] s_data,
    output logic       vs_rise,
    output logic       href_fall
);
    logic vsync_q, vsync_d1_q, href_q, href_d1_q;
    logic [7:0] data_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q    <= 1'b0;
            vsync_d1_q <= 1'b0;
            href_q     <= 1'b0;
            href_d1_q  <= 1'b0;
            data_q     <= 8'd0;
        end else begin
            vsync_q    <= cam_vsync;
            vsync_d1_q <= vsync_q;
            href_q     <= cam_href;
            href_d1_q  <= href_q;
            data_q     <= cam_data;
        end
    end
    assign s_href    = href_q;
    assign s_data    = data_q;
    assign vs_rise   = vsync_q & ~vsync_d1_q;
    assign href_fall = ~href_q & href_d1_q;
endmodule

// File: rtl/cmos_capture_pack.sv
// cmos_capture_pack: packs DVP byte pairs into RGB565 words (wr_en/wr_data), pulses wr_load per frame, flags frame_ready/line_err, counts frames
module cmos_capture_pack
    import sdram_cam_pkg::*;
#(
    parameter int H_PIXELS    = DEF_H_PIXELS,
    parameter int V_LINES     = DEF_V_LINES,
    parameter int WAIT_FRAMES = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_done,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    output logic             wr_en,
    output logic [PIX_W-1:0] wr_data,
    output logic             wr_load,
    output logic             frame_ready,
    output logic             line_err,
    output logic [15:0]      frame_cnt
);
    logic s_href, vs_rise, href_fall;
    logic [7:0] s_data;
    dvp_edge_sync u_sync (
        .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .s_href(s_href), .s_data(s_data), .vs_rise(vs_rise), .href_fall(href_fall)
    );
    logic [1:0] state_q, state_d;
    logic [7:0] skip_cnt_q, skip_cnt_d, hi_q, hi_d;
    logic frame_act_q, frame_act_d, byte_flag_q, byte_flag_d, frame_err_q, frame_err_d;
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic wr_en_q, wr_en_d, wr_load_q, wr_load_d, frame_ready_q, frame_ready_d, line_err_q, line_err_d;
    logic [PIX_W-1:0] wr_data_q, wr_data_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    always_comb begin
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        hi_d          = hi_q;
        frame_act_d   = frame_act_q;
        byte_flag_d   = byte_flag_q;
        frame_err_d   = frame_err_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;
        wr_load_d     = 1'b0;
        frame_ready_d = frame_ready_q;
        line_err_d    = line_err_q;
        frame_cnt_d   = frame_cnt_q;
        if (!cfg_done) begin
            state_d     = ST_WAIT_CFG;
            frame_act_d = 1'b0;
            byte_flag_d = 1'b0;
            frame_err_d = 1'b0;
            pix_cnt_d   = 12'd0;
            line_cnt_d  = 11'd0;
        end else if (state_q == ST_WAIT_CFG) begin
            state_d    = ST_SKIP;
            skip_cnt_d = 8'd0;
        end else if (state_q == ST_SKIP) begin
            if (vs_rise) begin
                skip_cnt_d = skip_cnt_q + 8'd1;
                state_d    = (skip_cnt_d == 8'(WAIT_FRAMES)) ? ST_RUN : ST_SKIP;
            end
        end else if (vs_rise) begin
            wr_load_d   = 1'b1;
            frame_act_d = 1'b1;
            byte_flag_d = 1'b0;
            frame_err_d = 1'b0;
            pix_cnt_d   = 12'd0;
            line_cnt_d  = 11'd0;
            line_err_d  = frame_act_q && (line_cnt_q != 11'(V_LINES) || s_href);
            if (frame_act_q) begin
                frame_cnt_d   = frame_cnt_q + 16'd1;
                frame_ready_d = frame_ready_q | ~(line_err_d | frame_err_q);
            end
        end else if (frame_act_q) begin
            if (s_href) begin
                byte_flag_d = ~byte_flag_q;
                hi_d        = byte_flag_q ? hi_q : s_data;
                wr_en_d     = byte_flag_q;
                wr_data_d   = byte_flag_q ? {hi_q, s_data} : wr_data_q;
                pix_cnt_d   = (byte_flag_q && pix_cnt_q != '1) ? pix_cnt_q + 12'd1 : pix_cnt_q;
            end else begin
                byte_flag_d = 1'b0;
                pix_cnt_d   = 12'd0;
                if (href_fall) begin
                    line_cnt_d = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + 11'd1;
                    if (pix_cnt_q != 12'(H_PIXELS) || byte_flag_q) begin
                        line_err_d  = 1'b1;
                        frame_err_d = 1'b1;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_WAIT_CFG;
            skip_cnt_q    <= 8'd0;
            hi_q          <= 8'd0;
            frame_act_q   <= 1'b0;
            byte_flag_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            pix_cnt_q     <= 12'd0;
            line_cnt_q    <= 11'd0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            wr_load_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            line_err_q    <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            hi_q          <= hi_d;
            frame_act_q   <= frame_act_d;
            byte_flag_q   <= byte_flag_d;
            frame_err_q   <= frame_err_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            wr_load_q     <= wr_load_d;
            frame_ready_q <= frame_ready_d;
            line_err_q    <= line_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end
    assign wr_en       = wr_en_q;
    assign wr_data     = wr_data_q;
    assign wr_load     = wr_load_q;
    assign frame_ready = frame_ready_q;
    assign line_err    = line_err_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_cmos_capture_pack.sv
// tb_cmos_capture_pack: randomized DVP frames against a frame-level scoreboard model
module tb_cmos_capture_pack;
    localparam int H = 8;
    localparam int V = 4;
    localparam int W = 2;
    logic clk = 1'b0, rst = 1'b1, cfg_done = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0;
    logic [7:0] cam_data = 8'd0;
    logic wr_en, wr_load, frame_ready, line_err;
    logic [15:0] wr_data, frame_cnt;
    typedef struct {logic [15:0] d; int c;} word_t;
    typedef struct {bit r; bit e; logic [15:0] n;} load_t;
    word_t word_q[$];
    load_t load_q[$];
    word_t mw;
    load_t ml;
    int checks = 0, errors = 0, cyc = 0;
    bit active, ferr, exp_err, exp_ready;
    int pulses, lines;
    logic [15:0] exp_cnt;
    cmos_capture_pack #(.H_PIXELS(H), .V_LINES(V), .WAIT_FRAMES(W)) dut (
        .clk(clk), .rst(rst), .cfg_done(cfg_done), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .wr_en(wr_en), .wr_data(wr_data), .wr_load(wr_load),
        .frame_ready(frame_ready), .line_err(line_err), .frame_cnt(frame_cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (word_q.size() == 0) chk("stray_wr_en", 1, 0);
                else begin
                    mw = word_q.pop_front();
                    chk("wr_data", wr_data, mw.d);
                    chk("wr_en_cycle", cyc, mw.c);
                end
            end
            if (wr_load) begin
                if (load_q.size() == 0) chk("stray_wr_load", 1, 0);
                else begin
                    ml = load_q.pop_front();
                    chk("load_frame_ready", frame_ready, ml.r);
                    chk("load_line_err", line_err, ml.e);
                    chk("load_frame_cnt", frame_cnt, ml.n);
                end
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic model_reset();
        active = 0; ferr = 0; exp_err = 0; exp_ready = 0; pulses = 0; lines = 0; exp_cnt = 0;
    endtask
    task automatic rst_cycles();
        rst = 1'b1;
        cam_href = 1'b0;
        repeat (5) begin
            tick();
            chk("rst_wr_en", wr_en, 0);
            chk("rst_wr_load", wr_load, 0);
            chk("rst_frame_ready", frame_ready, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
            chk("rst_line_err", line_err, 0);
            chk("rst_wr_data", wr_data, 0);
        end
        rst = 1'b0;
        model_reset();
        tick();
    endtask
    task automatic vsync_pulse();
        load_t l;
        if (cfg_done) begin
            pulses++;
            if (pulses > W) begin
                if (active) begin
                    exp_cnt++;
                    exp_err = (lines != V);
                    exp_ready = exp_ready | !(exp_err || ferr);
                end else exp_err = 0;
                l.r = exp_ready; l.e = exp_err; l.n = exp_cnt;
                load_q.push_back(l);
                active = 1; lines = 0; ferr = 0;
            end
        end
        cam_vsync = 1'b1;
        repeat (2) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
    endtask
    task automatic send_line(input int n, input bit dir);
        logic [7:0] b, hi;
        logic [7:0] dirb [4];
        word_t w;
        dirb = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        hi = 8'd0;
        for (int i = 0; i < n; i++) begin
            b = (dir && i < 4) ? dirb[i] : 8'($urandom);
            cam_href = 1'b1;
            cam_data = b;
            if (i % 2 == 0) hi = b;
            else if (active) begin
                w.d = {hi, b};
                w.c = cyc + 2;
                word_q.push_back(w);
            end
            tick();
        end
        cam_href = 1'b0;
        if (active) begin
            lines++;
            if (n != 2 * H) begin ferr = 1; exp_err = 1; end
        end
        repeat ($urandom_range(3, 6)) tick();
        chk("line_err", line_err, exp_err);
        chk("frame_ready", frame_ready, exp_ready);
        chk("frame_cnt", frame_cnt, exp_cnt);
    endtask
    task automatic send_frame(input int nl, input int bad, input int blen, input bit dir);
        vsync_pulse();
        for (int l = 0; l < nl; l++) send_line(l == bad ? blen : 2 * H, dir && l == 0);
    endtask
    initial begin
        model_reset();
        rst_cycles();
        cfg_done = 1'b1;
        repeat (3) tick();
        send_frame(V, -1, 0, 0);
        send_frame(V, -1, 0, 0);
        send_frame(V, -1, 0, 1);
        send_frame(V, 1, 2 * H - 1, 0);
        send_frame(V - 1, -1, 0, 0);
        send_frame(V, 2, 2 * H + 2, 0);
        send_frame(V, -1, 0, 0);
        send_frame(2, -1, 0, 0);
        cfg_done = 1'b0;
        active = 0;
        pulses = 0;
        repeat (2) tick();
        send_line(2 * H, 0);
        send_line(2 * H, 0);
        cfg_done = 1'b1;
        repeat (3) tick();
        repeat (4) send_frame(V, -1, 0, 0);
        send_frame(1, -1, 0, 0);
        cam_href = 1'b1;
        cam_data = 8'($urandom);
        tick();
        rst_cycles();
        repeat (3) tick();
        send_frame(V, -1, 0, 0);
        send_frame(V, -1, 0, 0);
        send_frame(V - 1, -1, 0, 0);
        send_frame(V, -1, 0, 0);
        vsync_pulse();
        repeat (10) tick();
        chk("words_left", word_q.size(), 0);
        chk("loads_left", load_q.size(), 0);
        chk("final_frame_ready", frame_ready, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
